// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, bus width,
// controller states and iteration-step modes.
package muldiv_ctrl_pkg;

    localparam int unsigned MD_OP_BUS = 3;

    localparam logic [MD_OP_BUS-1:0] MD_OP_MULT  = 3'd0;
    localparam logic [MD_OP_BUS-1:0] MD_OP_MULTU = 3'd1;
    localparam logic [MD_OP_BUS-1:0] MD_OP_DIV   = 3'd2;
    localparam logic [MD_OP_BUS-1:0] MD_OP_DIVU  = 3'd3;
    localparam logic [MD_OP_BUS-1:0] MD_OP_MTHI  = 3'd4;
    localparam logic [MD_OP_BUS-1:0] MD_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MD_STATE_IDLE,
        MD_STATE_MUL,
        MD_STATE_DIV,
        MD_STATE_DONE
    } md_state_t;

    typedef enum logic {
        MD_MODE_MUL,
        MD_MODE_DIV
    } md_mode_t;

endpackage

// File: rtl/muldiv_iter.sv
// One combinational step of the iterative datapath: unsigned shift-add
// multiply or restoring divide on a 64-bit {high, low} accumulator.
module muldiv_iter
    import muldiv_ctrl_pkg::*;
(
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    input  md_mode_t    mode,
    output logic [63:0] acc_next
);

    logic [32:0] sum;
    logic        fits;
    logic [31:0] rem_sub;

    always_comb begin
        sum     = {1'b0, acc[63:32]} + {1'b0, operand};
        // Shifted partial remainder is 33 bits; the 32-bit subtract is exact when it fits.
        fits    = acc[63:31] >= {1'b0, operand};
        rem_sub = acc[62:31] - operand;
        if (mode == MD_MODE_DIV) begin
            acc_next = fits ? {rem_sub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
        end else begin
            acc_next = acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; stalls EX until done.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned ITER_CNT = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MD_OP_BUS-1:0] op,
    input  logic [31:0]          operand_1,
    input  logic [31:0]          operand_2,
    input  logic                 flush,
    output logic                 stall_req,
    output logic                 done,
    output logic                 busy,
    output logic [31:0]          hi,
    output logic [31:0]          lo
);

    localparam int unsigned CNT_W = $clog2(ITER_CNT + 1);

    md_state_t        state, state_next;
    md_mode_t         mode;
    logic [CNT_W-1:0] counter;
    logic [63:0]      acc, acc_next;
    logic [31:0]      opnd;
    logic             neg_res, neg_rem;

    logic             is_mul, is_div, is_signed, div_zero, last_iter;
    logic [31:0]      mag_1, mag_2;
    logic [63:0]      prod_fix;
    logic [31:0]      quot_fix, rem_fix;

    always_comb begin
        is_mul    = (op == MD_OP_MULT) || (op == MD_OP_MULTU);
        is_div    = (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
        is_signed = (op == MD_OP_MULT) || (op == MD_OP_DIV);
        div_zero  = (operand_2 == '0);
        // -2^31 negates to itself, which is the correct unsigned magnitude.
        mag_1     = (is_signed && operand_1[31]) ? -operand_1 : operand_1;
        mag_2     = (is_signed && operand_2[31]) ? -operand_2 : operand_2;
        last_iter = (counter == CNT_W'(ITER_CNT - 1));
        mode      = (state == MD_STATE_DIV) ? MD_MODE_DIV : MD_MODE_MUL;
        prod_fix  = neg_res ? -acc_next : acc_next;
        quot_fix  = neg_res ? -acc_next[31:0] : acc_next[31:0];
        rem_fix   = neg_rem ? -acc_next[63:32] : acc_next[63:32];
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] ext_1, ext_2, fast_prod;

    always_comb begin
        ext_1     = is_signed ? {{32{operand_1[31]}}, operand_1} : {32'b0, operand_1};
        ext_2     = is_signed ? {{32{operand_2[31]}}, operand_2} : {32'b0, operand_2};
        fast_prod = ext_1 * ext_2;
    end
`endif

    muldiv_iter u_iter (
        .acc      (acc),
        .operand  (opnd),
        .mode     (mode),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= MD_STATE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = MD_STATE_IDLE;
        end else begin
            unique case (state)
                MD_STATE_IDLE: begin
                    if (start && is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                        state_next = MD_STATE_DONE;
`else
                        state_next = MD_STATE_MUL;
`endif
                    end else if (start && is_div) begin
                        state_next = div_zero ? MD_STATE_DONE : MD_STATE_DIV;
                    end
                end
                MD_STATE_MUL, MD_STATE_DIV: begin
                    if (last_iter) state_next = MD_STATE_DONE;
                end
                MD_STATE_DONE: state_next = MD_STATE_IDLE;
                default:       state_next = MD_STATE_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != MD_STATE_IDLE);
        done      = (state == MD_STATE_DONE) && !flush;
        stall_req = !flush &&
                    ((state == MD_STATE_MUL) || (state == MD_STATE_DIV) ||
                     ((state == MD_STATE_IDLE) && start && (is_mul || is_div)));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc     <= '0;
            opnd    <= '0;
            counter <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (!flush) begin
            unique case (state)
                MD_STATE_IDLE: begin
                    if (start) begin
                        counter <= '0;
                        if (op == MD_OP_MTHI) begin
                            hi <= operand_1;
                        end else if (op == MD_OP_MTLO) begin
                            lo <= operand_1;
                        end else if (is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                            {hi, lo} <= fast_prod;
`else
                            acc     <= {32'b0, mag_2};
                            opnd    <= mag_1;
                            neg_res <= is_signed && (operand_1[31] ^ operand_2[31]);
                            neg_rem <= 1'b0;
`endif
                        end else if (is_div) begin
                            if (div_zero) begin
                                hi <= operand_1;
                                lo <= '1;
                            end else begin
                                acc     <= {32'b0, mag_1};
                                opnd    <= mag_2;
                                neg_res <= is_signed && (operand_1[31] ^ operand_2[31]);
                                neg_rem <= is_signed && operand_1[31];
                            end
                        end
                    end
                end
                MD_STATE_MUL, MD_STATE_DIV: begin
                    acc     <= acc_next;
                    counter <= counter + CNT_W'(1);
                    if (last_iter) begin
                        if (state == MD_STATE_MUL) begin
                            {hi, lo} <= prod_fix;
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: scoreboard of expected HI/LO pushed
// at issue and popped on done, plus stall-length and flush/reset checks.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 33;
`endif
    localparam int DIV_STALL = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_1, operand_2;
    logic        flush;
    logic        stall_req, done, busy;
    logic [31:0] hi, lo;

    int tests  = 0;
    int failed = 0;
    logic [63:0] sb[$];

    muldiv_ctrl #(.ITER_CNT(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .flush     (flush),
        .stall_req (stall_req),
        .done      (done),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     sa, sb_, q, r;
        logic [63:0] up;
        sa  = a;
        sb_ = b;
        case (o)
            MD_OP_MULT: begin
                p = longint'(sa) * longint'(sb_);
                return p;
            end
            MD_OP_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                return up;
            end
            MD_OP_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb_;
                r = sa % sb_;
                return {r, q};
            end
            MD_OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the DONE edge with start still held.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int exp_stall, input string nm);
        int stalls  = 0;
        int done_at = -1;
        logic [63:0] e;
        sb.push_back(model(o, a, b));
        start = 1'b1; op = o; operand_1 = a; operand_2 = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stall_req) stalls++;
            if (done) begin
                done_at = i;
                break;
            end
            tick();
        end
        tests++;
        if (done_at !== exp_stall) begin
            failed++;
            $display("FAIL %s done_cycle: got %0d want %0d", nm, done_at, exp_stall);
        end
        tests++;
        if (stalls !== exp_stall) begin
            failed++;
            $display("FAIL %s stall_cycles: got %0d want %0d", nm, stalls, exp_stall);
        end
        e = sb.pop_front();
        if (done_at >= 0) begin
            tests++;
            if (hi !== e[63:32]) begin
                failed++;
                $display("FAIL %s hi: got %h want %h", nm, hi, e[63:32]);
            end
            tests++;
            if (lo !== e[31:0]) begin
                failed++;
                $display("FAIL %s lo: got %h want %h", nm, lo, e[31:0]);
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; operand_1 = '0; operand_2 = '0;
        repeat (2) tick();
        @(negedge clk);
        tests++;
        if ({hi, lo} !== 64'd0) begin
            failed++;
            $display("FAIL reset_hilo: got %h want 0", {hi, lo});
        end
        tests++;
        if ({busy, done, stall_req} !== 3'b000) begin
            failed++;
            $display("FAIL reset_flags: got %b want 000", {busy, done, stall_req});
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_mt(input logic [31:0] hv, input logic [31:0] lv);
        int stall_seen = 0;
        start = 1'b1; op = MD_OP_MTHI; operand_1 = hv;
        @(negedge clk);
        if (stall_req) stall_seen++;
        tick();
        op = MD_OP_MTLO; operand_1 = lv;
        @(negedge clk);
        if (stall_req) stall_seen++;
        tests++;
        if (hi !== hv) begin
            failed++;
            $display("FAIL mthi: got %h want %h", hi, hv);
        end
        tick();
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (lo !== lv) begin
            failed++;
            $display("FAIL mtlo: got %h want %h", lo, lv);
        end
        tests++;
        if (stall_seen !== 0) begin
            failed++;
            $display("FAIL mt_stall: got %0d cycles want 0", stall_seen);
        end
        tick();
    endtask

    task automatic test_arith();
        run_op(MD_OP_MULT,  32'hFFFF_FFFD, 32'd7, MUL_STALL, "mult_neg");
        run_op(MD_OP_MULTU, 32'hFFFF_FFFD, 32'd7, MUL_STALL, "multu");
        run_op(MD_OP_MULT,  32'h8000_0000, 32'h8000_0000, MUL_STALL, "mult_min");
        run_op(MD_OP_DIV,   32'hFFFF_FFF9, 32'd2, DIV_STALL, "div_neg");
        run_op(MD_OP_DIVU,  32'd100, 32'd7, DIV_STALL, "divu");
        run_op(MD_OP_DIV,   32'h8000_0000, 32'd2, DIV_STALL, "div_min");
        run_op(MD_OP_DIV,   32'd77, 32'hFFFF_FFF6, DIV_STALL, "div_negdiv");
        run_op(MD_OP_DIVU,  32'h55, 32'd0, 1, "divu_zero");
        run_op(MD_OP_DIV,   32'hFFFF_FF00, 32'd0, 1, "div_zero");
        start = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        test_mt(32'hAAAA_5555, 32'h1234_ABCD);
        start = 1'b1; op = MD_OP_DIV; operand_1 = 32'd1000; operand_2 = 32'd3;
        repeat (10) tick();
        @(negedge clk);
        tests++;
        if ({busy, stall_req} !== 2'b11) begin
            failed++;
            $display("FAIL flush_pre: busy/stall got %b want 11", {busy, stall_req});
        end
        tick();
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        tests++;
        if ({stall_req, done} !== 2'b00) begin
            failed++;
            $display("FAIL flush_cycle: stall/done got %b want 00", {stall_req, done});
        end
        tick();
        // flush must also beat a simultaneous MTHI
        start = 1'b1; op = MD_OP_MTHI; operand_1 = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, stall_req} !== 2'b00) begin
            failed++;
            $display("FAIL flush_idle: busy/stall got %b want 00", {busy, stall_req});
        end
        tests++;
        if ({hi, lo} !== {32'hAAAA_5555, 32'h1234_ABCD}) begin
            failed++;
            $display("FAIL flush_hilo: got %h want aaaa55551234abcd", {hi, lo});
        end
        tick();
        start = 1'b1; op = 3'd6;
        @(negedge clk);
        tests++;
        if (stall_req !== 1'b0) begin
            failed++;
            $display("FAIL undef_op_stall: got %b want 0", stall_req);
        end
        tick();
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL undef_op_busy: got %b want 0", busy);
        end
        tick();
    endtask

    task automatic test_rst_mid();
        start = 1'b1; op = MD_OP_DIV; operand_1 = 32'd1000; operand_2 = 32'd3;
        repeat (11) tick();
        rst = 1'b0; start = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({hi, lo} !== 64'd0) begin
            failed++;
            $display("FAIL rst_mid_hilo: got %h want 0", {hi, lo});
        end
        tests++;
        if ({busy, stall_req, done} !== 3'b000) begin
            failed++;
            $display("FAIL rst_mid_flags: got %b want 000", {busy, stall_req, done});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        run_op(MD_OP_MULT,  32'd2, 32'd3, MUL_STALL, "b2b_mult");
        run_op(MD_OP_MULTU, 32'd4, 32'd5, MUL_STALL, "b2b_multu");
        start = 1'b0;
        @(negedge clk);
        tests++;
        if ({hi, lo} !== 64'd20) begin
            failed++;
            $display("FAIL b2b_final: got %h want 20", {hi, lo});
        end
        tick();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_mt(32'h1234_5678, 32'h9ABC_DEF0);
        test_arith();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
